// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates ALU/LSU/MD write-backs onto two register file ports and tracks pending writes.
module regfile_wb_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid_i,
  input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
  input  logic [DATA_WIDTH-1:0] alu_wdata_i,
  output logic                  alu_ready_o,
  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_ready_o,
  input  logic                  md_valid_i,
  input  logic [ADDR_WIDTH-1:0] md_waddr_i,
  input  logic [DATA_WIDTH-1:0] md_wdata_i,
  output logic                  md_ready_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o,
  input  logic                  issue_i,
  input  logic [ADDR_WIDTH-1:0] issue_addr_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic                  busy_a_o,
  output logic                  busy_b_o,
  output logic                  issue_stall_o,
  input  logic                  flush_i
);
  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
  logic                  rr;
  logic                  both;
  logic                  sel_md;
  logic                  grant_a;
  logic [ADDR_WIDTH-1:0] cand_addr;
  logic [DATA_WIDTH-1:0] cand_data;
  logic [NUM_WORDS-1:0]  pending;
  logic [NUM_WORDS-1:0]  pending_nxt;
  logic [NUM_WORDS-1:0]  set_mask;
  logic [NUM_WORDS-1:0]  clr_mask;
  // Port A is withheld when it would race the LSU to the same nonzero register.
  always_comb begin
    both      = alu_valid_i && md_valid_i;
    sel_md    = both ? rr : md_valid_i;
    cand_addr = sel_md ? md_waddr_i : alu_waddr_i;
    cand_data = sel_md ? md_wdata_i : alu_wdata_i;
    grant_a   = (alu_valid_i || md_valid_i) &&
                !(lsu_valid_i && |cand_addr && cand_addr == lsu_waddr_i);
  end
  assign lsu_ready_o = lsu_valid_i;
  assign alu_ready_o = grant_a && !sel_md;
  assign md_ready_o  = grant_a && sel_md;
  // Issue set beats both same-cycle clears and flush; bit 0 never holds a hazard.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_i) set_mask[issue_addr_i] = 1'b1;
    if (lsu_valid_i) clr_mask[lsu_waddr_i] = 1'b1;
    if (grant_a) clr_mask[cand_addr] = 1'b1;
    pending_nxt = ((flush_i ? '0 : pending & ~clr_mask) | set_mask) &
                  {{(NUM_WORDS-1){1'b1}}, 1'b0};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr        <= 1'b0;
      pending   <= '0;
      we_a_o    <= 1'b0;
      we_b_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
    end else begin
      rr      <= (both && grant_a) ? ~rr : rr;
      pending <= pending_nxt;
      we_a_o  <= grant_a && |cand_addr;
      we_b_o  <= lsu_valid_i && |lsu_waddr_i;
      if (grant_a) begin
        waddr_a_o <= cand_addr;
        wdata_a_o <= cand_data;
      end
      if (lsu_valid_i) begin
        waddr_b_o <= lsu_waddr_i;
        wdata_b_o <= lsu_wdata_i;
      end
    end
  end
  assign busy_a_o      = pending[raddr_a_i];
  assign busy_b_o      = pending[raddr_b_i];
  assign issue_stall_o = pending[issue_addr_i];
endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the two-write-port integer register file. It arbitrates three write-back sources onto write ports A and B: the ALU, the load/store unit (LSU) and the multiply/divide unit (MD). It also keeps a per-register pending scoreboard, which the decode stage uses for read-after-write and write-after-write hazard detection. It sits between the execute/memory units and the register file, and its registered outputs drive the register file write ports directly.

## Interface
- ADDR_WIDTH, 5, register address width; NUM_WORDS = 2**ADDR_WIDTH
- DATA_WIDTH, 32, write data width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- alu_valid_i / lsu_valid_i / md_valid_i  in  1  write-back request per source
- alu_waddr_i / lsu_waddr_i / md_waddr_i  in  ADDR_WIDTH  destination register per source
- alu_wdata_i / lsu_wdata_i / md_wdata_i  in  DATA_WIDTH  write data per source
- alu_ready_o / lsu_ready_o / md_ready_o  out  1  request accepted this cycle (combinational)
- waddr_a_o, wdata_a_o, we_a_o  out  ADDR_WIDTH/DATA_WIDTH/1  register file port A (registered)
- waddr_b_o, wdata_b_o, we_b_o  out  ADDR_WIDTH/DATA_WIDTH/1  register file port B (registered)
- issue_i  in  1  decode issues an instruction that writes issue_addr_i
- issue_addr_i  in  ADDR_WIDTH  destination register of the issuing instruction
- raddr_a_i, raddr_b_i  in  ADDR_WIDTH  decode source operand addresses
- busy_a_o, busy_b_o  out  1  source operand has a pending write (combinational)
- issue_stall_o  out  1  issue_addr_i has a pending write (WAW hazard)
- flush_i  in  1  pipeline flush; clears the scoreboard

## Operation
- Handshake: a transfer occurs when valid_i && ready_o. A source holds valid, addr and data stable until the transfer. Ready never depends on the source's own ready.
- LSU has fixed priority and owns port B: lsu_ready_o = 1 whenever lsu_valid_i = 1.
- ALU and MD compete for port A:
  - Only one valid: it is granted.
  - Both valid: a 1-bit round-robin pointer rr decides (rr=0 ALU first, rr=1 MD first). rr flips to favour the loser only after a contended grant.
- Same-address rule: if the port A candidate has the same nonzero address as an LSU request in the same cycle, port A is not granted (its ready = 0). This keeps the write ordering deterministic.
- Address 0 writes: ready = 1 (accepted), but the corresponding we_*_o stays 0 and the scoreboard is unaffected.
- Output registers: each accepted transfer loads the port's addr and data registers and sets we for exactly one cycle. With no transfer, we_*_o = 0 and addr/data hold their last values.
- Scoreboard pending[NUM_WORDS-1:0]:
  - Set on issue_i at issue_addr_i (address 0 ignored).
  - Cleared on the edge where a transfer to that address is accepted.
  - Set and clear to the same address in the same cycle: set wins.
  - flush_i clears all bits, but set from a same-cycle issue_i still wins. Output registers already loaded still write.
  - pending[0] is always 0.
- Hazard outputs: busy_a_o = pending[raddr_a_i], busy_b_o = pending[raddr_b_i], issue_stall_o = pending[issue_addr_i].
  - No bypass: a write accepted this cycle still reads busy until the next edge.
- Issue while issue_stall_o = 1 is a protocol error; the bit stays set.

## Timing
- Reset (asynchronous, while rst_n = 0):
  - we_a_o = we_b_o = 0; waddr_*_o = 0; wdata_*_o = 0.
  - pending = 0; rr = 0.
  - busy_a_o, busy_b_o, issue_stall_o = 0.
  - All ready_o track the valid inputs combinationally and are meaningless during reset.
  - Reset asserted mid-transfer discards the registered write; we drops immediately.
- Latency: acceptance in cycle N → we_*_o = 1 in cycle N+1. The register file captures the data at the end of N+1, and the pending bit is clear from N+1.
- Throughput: at most two writes per cycle, one LSU and one ALU/MD. Sustained ALU+MD contention alternates grants, so neither source waits more than one cycle.
- The ready_o paths are purely combinational from valid and address inputs plus rr; there is no combinational path from we_*_o.

## Test plan
- Reset then single ALU write: alu_valid=1, waddr=5, wdata=0xDEADBEEF in cycle 1 → alu_ready=1 in cycle 1; we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF in cycle 2 only.
- Contention: ALU (addr 3) and MD (addr 4) valid for 4 cycles, rr=0 → grants ALU, MD, ALU, MD; each stalled source holds its request and completes within 2 cycles.
- LSU/ALU same address: LSU addr 7 and ALU addr 7 valid together → lsu_ready=1, alu_ready=0. Next cycle ALU granted; port B writes 7, then port A writes 7.
- Scoreboard: issue addr 9 → busy for raddr 9 from the next cycle. MD write to 9 accepted in cycle N → busy=1 in N, busy=0 in N+1. Issue to 9 in the acceptance cycle → bit stays 1.
- Address 0: ALU write to x0 → alu_ready=1, we_a_o stays 0. issue_addr=0 → issue_stall_o=0.
- Flush/reset mid-operation: pending {2,6} set, flush_i with issue to 6 → only pending[6]=1. Assert rst_n=0 while we_b_o=1 → we_b_o=0 immediately and pending all zero.
